// File: rtl/regfile_wb.sv
// Register file with a write-first bypass and a pending-write scoreboard.
// A combinational stall is raised on RAW and WAW hazards against outstanding writebacks.
module regfile_wb #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_en,
  input  logic [2:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  input  logic             rd_use_a,
  input  logic             rd_use_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             iss_en,
  input  logic [2:0]       iss_dst,
  output logic             stall,
  output logic [NREGS-1:0] pending
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             raw_a;
  logic             raw_b;
  logic             waw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // The set is written last so an issue and a writeback to the same register leave it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (wb_en) pending[wb_addr] <= 1'b0;
      if (iss_en && !stall) pending[iss_dst] <= 1'b1;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (wb_en && (wb_addr == rd_addr_a)) rd_data_a = wb_data;
    if (wb_en && (wb_addr == rd_addr_b)) rd_data_b = wb_data;
  end

  // A writeback landing this cycle resolves the hazard it would otherwise cause.
  always_comb begin
    raw_a = rd_use_a && pending[rd_addr_a] && !(wb_en && (wb_addr == rd_addr_a));
    raw_b = rd_use_b && pending[rd_addr_b] && !(wb_en && (wb_addr == rd_addr_b));
    waw   = iss_en && pending[iss_dst] && !(wb_en && (wb_addr == iss_dst));
    stall = raw_a || raw_b || waw;
  end

endmodule
